// File: rtl/gate_bist_if.sv
// Connection bundle between gate_bist and its surroundings: gate-block drive/observe
// lines plus run control and status. GATE_BIST_INJECT_EN adds the inject_err line.
interface gate_bist_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             drive_a;
  logic             drive_b;
  logic [6:0]       obs;
  logic [6:0]       fail_vec;
  logic [ERR_W-1:0] err_count;
`ifdef GATE_BIST_INJECT_EN
  logic             inject_err;

  modport master (
    input  start, obs, inject_err,
    output busy, done, pass, drive_a, drive_b, fail_vec, err_count
  );
  modport slave (
    output start, obs, inject_err,
    input  busy, done, pass, drive_a, drive_b, fail_vec, err_count
  );
`else
  modport master (
    input  start, obs,
    output busy, done, pass, drive_a, drive_b, fail_vec, err_count
  );
  modport slave (
    output start, obs,
    input  busy, done, pass, drive_a, drive_b, fail_vec, err_count
  );
`endif
endinterface

// File: rtl/gate_bist.sv
// BIST sequencer for the basic gate block: sweeps a/b through all four vectors and checks
// the seven gate outputs. Optional macro GATE_BIST_INJECT_EN adds a checker self-test input.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PassLast   = 8'(PASSES - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       fv_q, fv_d;

  logic       a, b;
  logic [6:0] expected;
  logic [6:0] mism;

  // The index register doubles as the registered drive for the gate block.
  assign a = idx_q[1];
  assign b = idx_q[0];

  always_comb begin
    expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
`ifdef GATE_BIST_INJECT_EN
    expected[0] = expected[0] ^ bus.inject_err;
`endif
    mism = bus.obs ^ expected;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    err_d      = err_q;
    fv_d       = fv_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d    = StSettle;
          idx_d      = 2'd0;
          pass_cnt_d = 8'd0;
          settle_d   = 8'd0;
          err_d      = '0;
          fv_d       = '0;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StSample: begin
        fv_d = fv_q | mism;
        if (mism != 7'd0 && err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        if (idx_q == 2'd3 && pass_cnt_q == PassLast) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 2'd1;
          settle_d = 8'd0;
          state_d  = StSettle;
          if (idx_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      pass_cnt_q <= 8'd0;
      settle_q   <= 8'd0;
      err_q      <= '0;
      fv_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign bus.drive_a   = a;
  assign bus.drive_b   = b;
  assign bus.busy      = (state_q == StSettle) || (state_q == StSample);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = (state_q == StDone) && (err_q == '0) && (fv_q == 7'd0);
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fv_q;

endmodule
